uart_tx_fifo: RTL and testbench

- Buffered UART transmitter directly downstream of the system controller.
- Absorbs the controller's one-cycle TX_P_DATA/TX_D_VLD byte strobes, including the back-to-back ALU result low/high byte pair, into a small synchronous FIFO.
- Serializes each byte as a UART frame (start, 8 data LSB-first, optional parity, stop), one bit per baud tick.
- Runs entirely in one clock domain; bit timing comes from the TICK enable input.

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/uart_tx_fifo_sync_fifo.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata always reflects the head while not empty.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a TICK-paced frame serializer
// (start, LSB-first data, optional parity, stop).
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              TICK,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  output logic              TX_OUT,
  output logic              Busy,
  output logic              FIFO_FULL,
  output logic              FIFO_EMPTY,
  output logic              OVERFLOW
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e            state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              par_en_r, par_en_s;
  logic              par_bit_r, par_bit_s;
  logic              tx_r, tx_s;
  logic              ovf_r;
  logic              pop_s;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  function automatic logic frame_parity(input logic [DATA_W-1:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  sync_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (DATA_VALID),
    .pop  (pop_s),
    .wdata(P_DATA),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign TX_OUT     = tx_r;
  assign Busy       = (state_r != IDLE);
  assign FIFO_FULL  = fifo_full;
  assign FIFO_EMPTY = fifo_empty;
  assign OVERFLOW   = ovf_r;

  // Serializer next-state and next-output logic; nothing moves without TICK.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    cnt_s     = cnt_r;
    par_en_s  = par_en_r;
    par_bit_s = par_bit_r;
    tx_s      = tx_r;
    pop_s     = 1'b0;
    if (TICK) begin
      case (state_r)
        IDLE, STOP: begin
          // STOP shares the IDLE load path so frames run back-to-back.
          if (!fifo_empty) begin
            pop_s     = 1'b1;
            shift_s   = fifo_rdata;
            par_en_s  = PAR_EN;
            par_bit_s = frame_parity(fifo_rdata, PAR_TYP);
            state_s   = START;
            tx_s      = 1'b0;
          end else begin
            state_s   = IDLE;
            tx_s      = 1'b1;
          end
        end
        START: begin
          tx_s    = shift_r[0];
          shift_s = {1'b0, shift_r[DATA_W-1:1]};
          cnt_s   = '0;
          state_s = DATA;
        end
        DATA: begin
          if (cnt_r != LAST_BIT) begin
            tx_s    = shift_r[0];
            shift_s = {1'b0, shift_r[DATA_W-1:1]};
            cnt_s   = cnt_r + CNT_ONE;
          end else if (par_en_r) begin
            tx_s    = par_bit_r;
            state_s = PARITY;
          end else begin
            tx_s    = 1'b1;
            state_s = STOP;
          end
        end
        PARITY: begin
          tx_s    = 1'b1;
          state_s = STOP;
        end
        default: begin
          tx_s    = 1'b1;
          state_s = IDLE;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Serializer registers; the line idles high out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      cnt_r     <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      cnt_r     <= cnt_s;
      par_en_r  <= par_en_s;
      par_bit_r <= par_bit_s;
      tx_r      <= tx_s;
    end
  end

  // Sticky drop flag, judged against the registered full flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_r <= 1'b0;
    end else if (DATA_VALID && fifo_full) begin
      ovf_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: an occupancy/frame-length model predicts frames, a line
// monitor decodes TX_OUT at each TICK and compares against the prediction.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       TICK;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT, Busy, FIFO_FULL, FIFO_EMPTY, OVERFLOW;

  logic manual_tick = 1'b0;
  logic auto_tick = 1'b0;
  int   tick_div = 0;
  int   div_cnt = 0;
  assign TICK = manual_tick | auto_tick;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .TICK(TICK),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy),
    .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [7:0] m_q[$];
  int   m_left = 0;
  logic m_busy = 1'b0;
  logic m_ovf = 1'b0;
  logic in_frame = 1'b0;
  int   pos = 0;
  logic [7:0] rx_bits = 8'h00;
  exp_t cur;
  logic prev_tx = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  always @(negedge CLK) begin
    if (tick_div == 0) begin
      auto_tick = 1'b0;
      div_cnt = 0;
    end else if (div_cnt == 0) begin
      auto_tick = 1'b1;
      div_cnt = tick_div - 1;
    end else begin
      auto_tick = 1'b0;
      div_cnt--;
    end
  end

  // Reference model: occupancy plus remaining bit periods of the current frame.
  always @(posedge CLK) begin
    if (!RST) begin
      logic full_before, do_pop;
      full_before = (m_q.size() == DEPTH);
      do_pop = TICK && (m_left == 0) && (m_q.size() > 0);
      if (DATA_VALID && full_before) m_ovf = 1'b1;
      if (do_pop) begin
        exp_t e;
        e.data = m_q.pop_front();
        e.pen  = PAR_EN;
        e.ptyp = PAR_TYP;
        exp_q.push_back(e);
        m_left = PAR_EN ? 10 : 9;
        m_busy = 1'b1;
      end else if (TICK) begin
        if (m_left > 0) m_left--;
        else m_busy = 1'b0;
      end
      if (DATA_VALID && !full_before) m_q.push_back(P_DATA);
      #1;
      check("fifo_full", FIFO_FULL, m_q.size() == DEPTH);
      check("fifo_empty", FIFO_EMPTY, m_q.size() == 0);
      check("overflow", OVERFLOW, m_ovf);
      check("busy", Busy, m_busy);
    end
  end

  // Line monitor: decodes frames bit by bit on TICK edges.
  always @(posedge CLK) begin
    if (!RST) begin
      logic t;
      t = TICK;
      #1;
      if (!t) begin
        check("tx_hold", TX_OUT, prev_tx);
      end else if (!in_frame) begin
        if (TX_OUT == 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            in_frame = 1'b1;
            pos = 0;
          end
        end
      end else begin
        pos++;
        if (pos <= 8) begin
          rx_bits[pos-1] = TX_OUT;
        end else if (cur.pen && pos == 9) begin
          check("parity_bit", TX_OUT, ($countones(cur.data) % 2 == 1) ^ cur.ptyp);
        end else begin
          check("stop_bit", TX_OUT, 1);
          check("frame_data", rx_bits, cur.data);
          in_frame = 1'b0;
        end
      end
      prev_tx = TX_OUT;
    end
  end

  task automatic push(input logic [7:0] b);
    DATA_VALID = 1'b1;
    P_DATA = b;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic mtick(input int n);
    for (int i = 0; i < n; i++) begin
      manual_tick = 1'b1;
      @(negedge CLK);
      manual_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", Busy, 0);
    check("rst_empty", FIFO_EMPTY, 1);
    m_q.delete();
    exp_q.delete();
    m_left = 0;
    m_busy = 1'b0;
    m_ovf = 1'b0;
    in_frame = 1'b0;
    prev_tx = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((m_q.size() != 0 || m_busy) && i < 5000) begin
      @(negedge CLK);
      i++;
    end
    check({name, "_timeout"}, (m_q.size() != 0 || m_busy), 0);
    repeat (2) @(negedge CLK);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_in_frame"}, in_frame, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("reset_tx", TX_OUT, 1);
    check("reset_busy", Busy, 0);
    check("reset_empty", FIFO_EMPTY, 1);
    check("reset_full", FIFO_FULL, 0);
    check("reset_ovf", OVERFLOW, 0);
    RST = 1'b0;

    // Single byte, no parity, slow baud.
    tick_div = 16;
    push(8'hA5);
    drain("a5");

    // Parity even then odd.
    tick_div = 4;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    push(8'h03);
    drain("par_even");
    PAR_TYP = 1'b1;
    push(8'h03);
    drain("par_odd");
    PAR_EN = 1'b0;

    // ALU low/high pair in consecutive cycles.
    tick_div = 3;
    push(8'h34);
    push(8'h12);
    drain("pair");

    // Overfill with TICK held low.
    tick_div = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("fill_full", FIFO_FULL, 1);
    check("fill_ovf", OVERFLOW, 1);
    tick_div = 2;
    drain("fill");

    // Push while full on the same edge as a STOP-state pop.
    tick_div = 0;
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    mtick(1);
    push(8'h44);
    check("stop_pre_full", FIFO_FULL, 1);
    mtick(9);
    DATA_VALID = 1'b1;
    P_DATA = 8'hEE;
    manual_tick = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    manual_tick = 1'b0;
    check("stop_pop_full", FIFO_FULL, 0);
    check("stop_pop_ovf", OVERFLOW, 1);
    check("stop_pop_busy", Busy, 1);
    tick_div = 2;
    drain("stop_pop");

    // Reset during data bit 4, with a second byte queued.
    tick_div = 0;
    push(8'h5A);
    push(8'h77);
    mtick(6);
    check("mid_busy", Busy, 1);
    do_reset();
    tick_div = 4;
    push(8'hFF);
    drain("after_rst");

    // Randomized traffic, baud rate and parity settings.
    for (int i = 0; i < 600; i++) begin
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA = 8'($urandom);
      if ($urandom_range(0, 15) == 0) PAR_EN = 1'($urandom);
      if ($urandom_range(0, 15) == 0) PAR_TYP = 1'($urandom);
      if ($urandom_range(0, 63) == 0) tick_div = $urandom_range(1, 4);
      @(negedge CLK);
    end
    DATA_VALID = 1'b0;
    tick_div = 2;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
